// File: rtl/window_scan_ctrl_if.sv
// Bundles the frame-memory read port, the window-buffer command port and the
// window handshake towards the Sobel stage. master = sequencer side.
interface window_scan_ctrl_if #(
   parameter int ADDR_W = 19
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [7:0]        mem_rdata;
   logic              wb_start_read;
   logic              wb_start_shift;
   logic [1:0]        wb_shift_direc;
   logic [7:0]        wb_data;
   logic              win_valid;
   logic              win_ready;
   logic [15:0]       win_x;
   logic [15:0]       win_y;

   modport master (
      output mem_req, mem_addr, wb_start_read, wb_start_shift, wb_shift_direc,
             wb_data, win_valid, win_x, win_y,
      input  mem_rvalid, mem_rdata, win_ready
   );

   modport slave (
      input  mem_req, mem_addr, wb_start_read, wb_start_shift, wb_shift_direc,
             wb_data, win_valid, win_x, win_y,
      output mem_rvalid, mem_rdata, win_ready
   );
endinterface

// File: rtl/window_scan_ctrl.sv
// Serpentine 3x3 window sequencer: fetches pixels, drives the window buffer
// and hands windows to the kernel. Optional WSC_STALL_CNT_EN adds stall_cycles.
module window_scan_ctrl #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ADDR_W = 19
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   window_scan_ctrl_if.master bus
`ifdef WSC_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FILL, S_EMIT, S_SHIFT, S_COL, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] W2_A   = ADDR_W'(2 * IMG_W);
   localparam logic [ADDR_W-1:0] WM2_A  = ADDR_W'(IMG_W - 2);
   localparam logic [15:0]       X_LAST = 16'(IMG_W - 3);
   localparam logic [15:0]       Y_LAST = 16'(IMG_H - 3);

   state_t            state_reg;
   logic [15:0]       x_reg, y_reg;
   logic [ADDR_W-1:0] row_base_reg;
   logic              right_reg;
   logic [3:0]        rd_cnt_reg;
   logic [1:0]        col_cnt_reg;
   logic              wait_reg;
   logic [ADDR_W-1:0] step_reg;
   logic              mem_req_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic              shift_reg;
   logic [1:0]        direc_reg;
   logic              win_valid_reg;
   logic              done_reg;
   logic              busy_reg;

   logic reading, rd_done, last_win;

   assign reading  = (state_reg == S_FILL) || (state_reg == S_COL);
   // Only a response to our own outstanding request advances the read sequence.
   assign rd_done  = reading && wait_reg && bus.mem_rvalid;
   assign last_win = (y_reg == Y_LAST) &&
                     (right_reg ? (x_reg == X_LAST) : (x_reg == 16'd0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         x_reg         <= '0;
         y_reg         <= '0;
         row_base_reg  <= '0;
         right_reg     <= 1'b1;
         rd_cnt_reg    <= '0;
         col_cnt_reg   <= '0;
         wait_reg      <= 1'b0;
         step_reg      <= '0;
         mem_req_reg   <= 1'b0;
         mem_addr_reg  <= '0;
         shift_reg     <= 1'b0;
         direc_reg     <= 2'b00;
         win_valid_reg <= 1'b0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         mem_req_reg <= 1'b0;
         shift_reg   <= 1'b0;
         done_reg    <= 1'b0;
         if (rd_done)
            wait_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg    <= S_CLEAR;
                  x_reg        <= '0;
                  y_reg        <= '0;
                  row_base_reg <= '0;
                  right_reg    <= 1'b1;
                  busy_reg     <= 1'b1;
                  shift_reg    <= 1'b1;
                  direc_reg    <= 2'b00;
               end
            end
            S_CLEAR: begin
               state_reg    <= S_FILL;
               mem_req_reg  <= 1'b1;
               mem_addr_reg <= row_base_reg + ADDR_W'(x_reg);
               wait_reg     <= 1'b1;
               rd_cnt_reg   <= '0;
               col_cnt_reg  <= '0;
            end
            S_FILL: begin
               if (rd_done) begin
                  if (rd_cnt_reg == 4'd8) begin
                     state_reg     <= S_EMIT;
                     win_valid_reg <= 1'b1;
                  end else begin
                     mem_req_reg <= 1'b1;
                     wait_reg    <= 1'b1;
                     rd_cnt_reg  <= rd_cnt_reg + 4'd1;
                     if (col_cnt_reg == 2'd2) begin
                        col_cnt_reg  <= '0;
                        mem_addr_reg <= mem_addr_reg + WM2_A;
                     end else begin
                        col_cnt_reg  <= col_cnt_reg + 2'd1;
                        mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
                     end
                  end
               end
            end
            S_EMIT: begin
               if (bus.win_ready) begin
                  win_valid_reg <= 1'b0;
                  if (last_win) begin
                     state_reg <= S_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= S_SHIFT;
                     shift_reg <= 1'b1;
                     if (right_reg && (x_reg < X_LAST)) begin
                        direc_reg <= 2'b01;
                        x_reg     <= x_reg + 16'd1;
                     end else if (!right_reg && (x_reg > 16'd0)) begin
                        direc_reg <= 2'b10;
                        x_reg     <= x_reg - 16'd1;
                     end else begin
                        direc_reg    <= 2'b11;
                        y_reg        <= y_reg + 16'd1;
                        row_base_reg <= row_base_reg + W_A;
                        right_reg    <= ~right_reg;
                     end
                  end
               end
            end
            S_SHIFT: begin
               // Anchor is already moved; pick the column/row that just entered.
               state_reg   <= S_COL;
               mem_req_reg <= 1'b1;
               wait_reg    <= 1'b1;
               rd_cnt_reg  <= '0;
               case (direc_reg)
                  2'b01: begin
                     mem_addr_reg <= row_base_reg + ADDR_W'(x_reg) + ADDR_W'(2);
                     step_reg     <= W_A;
                  end
                  2'b10: begin
                     mem_addr_reg <= row_base_reg + ADDR_W'(x_reg);
                     step_reg     <= W_A;
                  end
                  default: begin
                     mem_addr_reg <= row_base_reg + W2_A + ADDR_W'(x_reg);
                     step_reg     <= ADDR_W'(1);
                  end
               endcase
            end
            S_COL: begin
               if (rd_done) begin
                  if (rd_cnt_reg == 4'd2) begin
                     state_reg     <= S_EMIT;
                     win_valid_reg <= 1'b1;
                  end else begin
                     mem_req_reg  <= 1'b1;
                     wait_reg     <= 1'b1;
                     rd_cnt_reg   <= rd_cnt_reg + 4'd1;
                     mem_addr_reg <= mem_addr_reg + step_reg;
                  end
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign busy               = busy_reg;
   assign done               = done_reg;
   assign bus.mem_req        = mem_req_reg;
   assign bus.mem_addr       = mem_addr_reg;
   assign bus.wb_start_read  = reading && bus.mem_rvalid;
   assign bus.wb_start_shift = shift_reg;
   assign bus.wb_shift_direc = direc_reg;
   assign bus.wb_data        = bus.mem_rdata;
   assign bus.win_valid      = win_valid_reg;
   assign bus.win_x          = x_reg;
   assign bus.win_y          = y_reg;

`ifdef WSC_STALL_CNT_EN
   logic [31:0] stall_reg;
   logic        stall_now;

   // A read cycle is a stall only beyond the minimum one-cycle latency.
   assign stall_now = ((state_reg == S_EMIT) && !bus.win_ready) ||
                      (reading && wait_reg && !bus.mem_rvalid && !mem_req_reg);

   always_ff @(posedge clk) begin
      if (rst)
         stall_reg <= '0;
      else if ((state_reg == S_IDLE) && start)
         stall_reg <= '0;
      else if (stall_now && (stall_reg != '1))
         stall_reg <= stall_reg + 32'd1;
   end

   assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl on a 5x4 image: serpentine window
// order, addresses, data order, handshake stalls, random latency and reset.
module tb_window_scan_ctrl;
   localparam int W    = 5;
   localparam int H    = 4;
   localparam int AW   = 19;
   localparam int NWIN = (W - 2) * (H - 2);
   localparam int NRD  = 9 + 3 * (NWIN - 1);

   logic clk = 1'b0;
   logic rst, start, busy, done;
`ifdef WSC_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   window_scan_ctrl_if #(.ADDR_W(AW)) bus ();

   window_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
`ifdef WSC_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] pix [W*H];
   int ex_x[$], ex_y[$], ex_dir[$], ex_addr[$];

   // Memory responder: one response per request after 1 (or random 1..4) cycles.
   bit rand_lat = 1'b0;
   int rcnt = 0;
   int raddr = 0;
   int ovl = 0;
   always @(posedge clk) begin
      #1;
      bus.mem_rvalid = 1'b0;
      if (rst) begin
         rcnt = 0;
      end else begin
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = (raddr < W*H) ? pix[raddr] : 8'hxx;
            end
         end
         if (bus.mem_req) begin
            if (rcnt > 0) ovl++;
            rcnt  = rand_lat ? int'($urandom_range(4, 1)) : 1;
            raddr = int'(bus.mem_addr);
         end
      end
   end

   // Monitor: records observable transactions at the falling edge.
   int q_addr[$], q_data[$], q_dir[$], q_wx[$], q_wy[$], q_acc[$], q_done[$];
   int first_valid = -1;
   int unstable = 0;
   logic prev_v = 1'b0, prev_acc = 1'b0;
   logic [15:0] prev_x = '0, prev_y = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_req) q_addr.push_back(int'(bus.mem_addr));
         if (bus.wb_start_read) q_data.push_back(int'(bus.wb_data));
         if (bus.wb_start_shift && bus.wb_shift_direc != 2'b00)
            q_dir.push_back(int'(bus.wb_shift_direc));
         if (bus.win_valid && first_valid < 0) first_valid = cyc;
         if (prev_v && !prev_acc &&
             (!bus.win_valid || bus.win_x != prev_x || bus.win_y != prev_y))
            unstable++;
         if (bus.win_valid && bus.win_ready) begin
            q_wx.push_back(int'(bus.win_x));
            q_wy.push_back(int'(bus.win_y));
            q_acc.push_back(cyc);
         end
         if (done) q_done.push_back(cyc);
      end
      prev_v   = bus.win_valid && !rst;
      prev_acc = bus.win_ready;
      prev_x   = bus.win_x;
      prev_y   = bus.win_y;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: serpentine anchors, moves and the pixels each step must fetch.
   task automatic build_model();
      for (int y = 0; y <= H - 3; y++)
         for (int k = 0; k <= W - 3; k++) begin
            ex_x.push_back((y % 2 == 0) ? k : (W - 3 - k));
            ex_y.push_back(y);
         end
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) ex_addr.push_back(r * W + c);
      for (int i = 1; i < NWIN; i++) begin
         int d;
         if (ex_y[i] != ex_y[i-1]) d = 3;
         else if (ex_x[i] > ex_x[i-1]) d = 1;
         else d = 2;
         ex_dir.push_back(d);
         for (int j = 0; j < 3; j++) begin
            if (d == 1)      ex_addr.push_back((ex_y[i] + j) * W + ex_x[i] + 2);
            else if (d == 2) ex_addr.push_back((ex_y[i] + j) * W + ex_x[i]);
            else             ex_addr.push_back((ex_y[i] + 2) * W + ex_x[i] + j);
         end
      end
   endtask

   task automatic clear_mon();
      q_addr.delete(); q_data.delete(); q_dir.delete();
      q_wx.delete(); q_wy.delete(); q_acc.delete(); q_done.delete();
      first_valid = -1;
      unstable = 0;
      ovl = 0;
   endtask

   int t0 = 0;
   task automatic pulse_start();
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound && q_done.size() == 0; i++) @(negedge clk);
      chk("done_timeout", int'(q_done.size() > 0), 1);
      repeat (2) @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
   endtask

   task automatic check_frame(input bit timing);
      chk("n_req", q_addr.size(), NRD);
      for (int i = 0; i < NRD; i++) begin
         chk("addr", (i < q_addr.size()) ? q_addr[i] : -1, ex_addr[i]);
         chk("wb_data", (i < q_data.size()) ? q_data[i] : -1, int'(pix[ex_addr[i]]));
      end
      chk("n_win", q_acc.size(), NWIN);
      for (int i = 0; i < NWIN; i++) begin
         chk("win_x", (i < q_wx.size()) ? q_wx[i] : -1, ex_x[i]);
         chk("win_y", (i < q_wy.size()) ? q_wy[i] : -1, ex_y[i]);
      end
      chk("n_dir", q_dir.size(), NWIN - 1);
      for (int i = 0; i < NWIN - 1; i++)
         chk("direc", (i < q_dir.size()) ? q_dir[i] : -1, ex_dir[i]);
      chk("n_done", q_done.size(), 1);
      chk("done_lat", (q_done.size() > 0 && q_acc.size() > 0) ?
                      q_done[0] - q_acc[q_acc.size()-1] : -1, 1);
      chk("one_outstanding", ovl, 0);
      chk("win_stable", unstable, 0);
      if (timing) begin
         chk("first_valid_cyc", first_valid - t0, 20);
         for (int i = 1; i < q_acc.size(); i++)
            chk("accept_spacing", q_acc[i] - q_acc[i-1], 8);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      bus.win_ready = 1'b1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = 8'h00;
      for (int i = 0; i < W*H; i++) pix[i] = 8'($urandom);
      build_model();
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mem_req", int'(bus.mem_req), 0);
      chk("rst_mem_addr", int'(bus.mem_addr), 0);
      chk("rst_wb_read", int'(bus.wb_start_read), 0);
      chk("rst_wb_shift", int'(bus.wb_start_shift), 0);
      chk("rst_direc", int'(bus.wb_shift_direc), 0);
      chk("rst_win_valid", int'(bus.win_valid), 0);
      chk("rst_win_x", int'(bus.win_x), 0);
      chk("rst_win_y", int'(bus.win_y), 0);
      rst = 1'b0;
      @(negedge clk);

      // Full frame, latency 1, with a stray start mid-frame
      clear_mon();
      pulse_start();
      repeat (29) @(negedge clk);
      chk("busy_mid", int'(busy), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2000);
      repeat (20) @(negedge clk);
      check_frame(1'b1);
      $display("frame A: %0d reads, %0d windows", q_addr.size(), q_acc.size());

      // Kernel back-pressure on window 2
      clear_mon();
      pulse_start();
      for (int i = 0; i < 200 && q_acc.size() < 1; i++) @(negedge clk);
      @(negedge clk);
      bus.win_ready = 1'b0;
      for (int i = 0; i < 40 && !bus.win_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_valid", int'(bus.win_valid), 1);
         chk("stall_x", int'(bus.win_x), 1);
         chk("stall_y", int'(bus.win_y), 0);
         chk("stall_no_req", int'(bus.mem_req), 0);
      end
      @(negedge clk);
      bus.win_ready = 1'b1;
      wait_done(2000);
      check_frame(1'b0);
`ifdef WSC_STALL_CNT_EN
      chk("stall_cycles", int'(stall_cycles), 5);
`endif
      $display("frame B: stalled window 2, %0d windows", q_acc.size());

      // Random read latency 1..4
      rand_lat = 1'b1;
      for (int f = 0; f < 2; f++) begin
         clear_mon();
         pulse_start();
         wait_done(5000);
         check_frame(1'b0);
         $display("frame C%0d: random latency, %0d reads", f, q_addr.size());
      end
      rand_lat = 1'b0;

      // Reset during a column fetch, then restart
      clear_mon();
      pulse_start();
      for (int i = 0; i < 200 && q_dir.size() < 1; i++) @(negedge clk);
      for (int i = 0; i < 20 && !bus.mem_req; i++) @(negedge clk);
      chk("col_req_seen", int'(bus.mem_req), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_mem_req", int'(bus.mem_req), 0);
      chk("mid_rst_mem_addr", int'(bus.mem_addr), 0);
      chk("mid_rst_wb_read", int'(bus.wb_start_read), 0);
      chk("mid_rst_wb_shift", int'(bus.wb_start_shift), 0);
      chk("mid_rst_direc", int'(bus.wb_shift_direc), 0);
      chk("mid_rst_valid", int'(bus.win_valid), 0);
      chk("mid_rst_x", int'(bus.win_x), 0);
      chk("mid_rst_y", int'(bus.win_y), 0);
      chk("mid_rst_done", int'(done), 0);
      rst = 1'b0;
      @(negedge clk);
      clear_mon();
      pulse_start();
      wait_done(2000);
      check_frame(1'b1);
      $display("frame D: restart after reset, first addr %0d",
               (q_addr.size() > 0) ? q_addr[0] : -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
